// File: rtl/modexp_pkg.sv
// Shared types for the square-and-multiply exponentiation engine.
package modexp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        REDUCE = 3'd2,
        MUL    = 3'd3,
        SHIFT  = 3'd4,
        SQR    = 3'd5,
        FIN    = 3'd6
    } state_e;

    // Operand selection for the modular multiplier.
    typedef enum logic [1:0] {
        OP_REDUCE = 2'd0,
        OP_MUL    = 2'd1,
        OP_SQR    = 2'd2
    } mm_op_e;

endpackage

// File: rtl/modmul_serial.sv
// Interleaved shift-add modular multiplier, MSB-first over b, one multiplier bit per cycle.
module modmul_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mm_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             mm_done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] a_r, n_r, b_r, p_r;
    logic [CW-1:0]    cnt_r;
    logic             done_r;

    // One interleaved step: double, reduce, conditionally add a, reduce. All terms stay below 2n.
    function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] p_in,
                                                 input logic [WIDTH-1:0] a_in,
                                                 input logic [WIDTH-1:0] n_in,
                                                 input logic             bit_in);
        logic [WIDTH:0] nn, t0, t1, t2, t3;
        nn = {1'b0, n_in};
        t0 = {p_in, 1'b0};
        t1 = (t0 >= nn) ? (t0 - nn) : t0;
        t2 = bit_in ? (t1 + {1'b0, a_in}) : t1;
        t3 = (t2 >= nn) ? (t2 - nn) : t2;
        return t3[WIDTH-1:0];
    endfunction

    // The load cycle already consumes the top multiplier bit, so the product is ready WIDTH cycles after start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r    <= ZERO;
            n_r    <= ZERO;
            b_r    <= ZERO;
            p_r    <= ZERO;
            cnt_r  <= CNT_ZERO;
            done_r <= 1'b0;
        end else if (mm_start) begin
            a_r    <= a;
            n_r    <= n;
            b_r    <= {b[WIDTH-2:0], 1'b0};
            p_r    <= mm_step(ZERO, a, n, b[WIDTH-1]);
            cnt_r  <= CNT_LOAD;
            done_r <= 1'b0;
        end else if (cnt_r != CNT_ZERO) begin
            p_r    <= mm_step(p_r, a_r, n_r, b_r[WIDTH-1]);
            b_r    <= {b_r[WIDTH-2:0], 1'b0};
            cnt_r  <= cnt_r - CNT_ONE;
            done_r <= (cnt_r == CNT_ONE);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign p       = p_r;
    assign mm_done = done_r;

endmodule

// File: rtl/modexp_sqmul.sv
// Right-to-left binary square-and-multiply: result = base^exponent mod modulus.
module modexp_sqmul
    import modexp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic [WIDTH-1:0] base_r, mod_r, e_r, acc_r, b_r, result_r;
    logic             err_r, mm_wait_r, busy_r, done_r, error_r;
    mm_op_e           mm_op_s;
    logic             mm_start_s, mm_done_s, e_more_s;
    logic [WIDTH-1:0] mm_a_s, mm_b_s, mm_p_s;

    assign e_more_s = |e_r[WIDTH-1:1];

    // Issue a multiplier op on the first cycle of REDUCE/MUL; SHIFT doubles as the squaring issue cycle.
    always_comb begin
        mm_op_s    = OP_REDUCE;
        mm_start_s = 1'b0;
        case (state_r)
            REDUCE: begin
                mm_op_s    = OP_REDUCE;
                mm_start_s = ~mm_wait_r;
            end
            MUL: begin
                mm_op_s    = OP_MUL;
                mm_start_s = ~mm_wait_r;
            end
            SHIFT: begin
                mm_op_s    = OP_SQR;
                mm_start_s = 1'b1;
            end
            default: begin
                mm_op_s    = OP_REDUCE;
                mm_start_s = 1'b0;
            end
        endcase
    end

    // Operand select; reduction multiplies by one so the base is brought below the modulus.
    always_comb begin
        mm_a_s = ONE;
        mm_b_s = base_r;
        case (mm_op_s)
            OP_REDUCE: begin
                mm_a_s = ONE;
                mm_b_s = base_r;
            end
            OP_MUL: begin
                mm_a_s = acc_r;
                mm_b_s = b_r;
            end
            OP_SQR: begin
                mm_a_s = b_r;
                mm_b_s = b_r;
            end
            default: begin
                mm_a_s = ONE;
                mm_b_s = base_r;
            end
        endcase
    end

    modmul_serial #(
        .WIDTH(WIDTH)
    ) u_modmul (
        .clk     (clk),
        .reset_n (reset_n),
        .mm_start(mm_start_s),
        .a       (mm_a_s),
        .b       (mm_b_s),
        .n       (mod_r),
        .p       (mm_p_s),
        .mm_done (mm_done_s)
    );

    // Control FSM with datapath registers; outputs land one edge after FIN and busy covers that done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            base_r    <= ZERO;
            mod_r     <= ZERO;
            e_r       <= ZERO;
            acc_r     <= ZERO;
            b_r       <= ZERO;
            err_r     <= 1'b0;
            mm_wait_r <= 1'b0;
            result_r  <= ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !busy_r) begin
                        base_r  <= base;
                        e_r     <= exponent;
                        mod_r   <= modulus;
                        err_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= CHECK;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                CHECK: begin
                    mm_wait_r <= 1'b0;
                    if (mod_r == ZERO) begin
                        acc_r   <= ZERO;
                        err_r   <= 1'b1;
                        state_r <= FIN;
                    end else if (mod_r == ONE) begin
                        acc_r   <= ZERO;
                        state_r <= FIN;
                    end else if (e_r == ZERO) begin
                        acc_r   <= ONE;
                        state_r <= FIN;
                    end else begin
                        acc_r   <= ONE;
                        state_r <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (!mm_wait_r) begin
                        mm_wait_r <= 1'b1;
                    end else if (mm_done_s) begin
                        mm_wait_r <= 1'b0;
                        b_r       <= mm_p_s;
                        state_r   <= e_r[0] ? MUL : SHIFT;
                    end else begin
                        mm_wait_r <= 1'b1;
                    end
                end
                MUL: begin
                    if (!mm_wait_r) begin
                        mm_wait_r <= 1'b1;
                    end else if (mm_done_s) begin
                        mm_wait_r <= 1'b0;
                        acc_r     <= mm_p_s;
                        state_r   <= e_more_s ? SHIFT : FIN;
                    end else begin
                        mm_wait_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    e_r       <= {1'b0, e_r[WIDTH-1:1]};
                    mm_wait_r <= 1'b1;
                    state_r   <= SQR;
                end
                SQR: begin
                    // Only entered with a non-zero shifted exponent, so the loop always continues.
                    if (mm_done_s) begin
                        mm_wait_r <= 1'b0;
                        b_r       <= mm_p_s;
                        state_r   <= e_r[0] ? MUL : SHIFT;
                    end else begin
                        mm_wait_r <= 1'b1;
                    end
                end
                FIN: begin
                    result_r <= acc_r;
                    error_r  <= err_r;
                    done_r   <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign error  = error_r;

endmodule
